// File: rtl/capture_streamer.sv
// capture_streamer: reads word_count words from capture RAM (forward or
// reverse, wrapping modulo depth) and serialises each word into bytes on the
// valid/active UART byte handshake.
module capture_streamer #(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned DATA_BYTES = 1,
    parameter bit          MSB_FIRST  = 1'b0
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    run,
    input  logic                    abort,
    input  logic                    reverse,
    input  logic [ADDR_WIDTH-1:0]   start_address,
    input  logic [ADDR_WIDTH:0]     word_count,
    input  logic [8*DATA_BYTES-1:0] read_data,
    output logic [ADDR_WIDTH-1:0]   read_address,
    input  logic                    serial_output_active,
    output logic                    serial_output_valid,
    output logic [7:0]              serial_output_data,
    output logic                    busy,
    output logic                    finished
);

    localparam int unsigned DATA_W = 8 * DATA_BYTES;
    localparam int unsigned IDX_W  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int unsigned CNT_W  = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        LATCH    = 2'd2,
        SEND     = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                reverse_q, reverse_d;
    logic [CNT_W-1:0]    words_left_q, words_left_d;
    logic [IDX_W-1:0]    byte_idx_q, byte_idx_d;
    logic [DATA_W-1:0]   word_buf_q, word_buf_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                valid_d;
    logic [7:0]          data_d;
    logic                busy_d;
    logic                finished_d;

    logic [IDX_W-1:0]    sel_c;
    logic [7:0]          cur_byte_c;
    logic                last_byte_c;

    // Pick the byte of the latched word addressed by byte_idx in send order.
    always_comb begin
        cur_byte_c  = 8'd0;
        sel_c       = MSB_FIRST ? (IDX_W'(DATA_BYTES - 1) - byte_idx_q) : byte_idx_q;
        last_byte_c = (byte_idx_q == IDX_W'(DATA_BYTES - 1));
        for (int unsigned b = 0; b < DATA_BYTES; b++) begin
            if (sel_c == IDX_W'(b)) begin
                cur_byte_c = word_buf_q[8*b +: 8];
            end
        end
    end

    // Next-state and next-output logic; abort overrides every other action.
    always_comb begin
        state_d      = state_q;
        reverse_d    = reverse_q;
        words_left_d = words_left_q;
        byte_idx_d   = byte_idx_q;
        word_buf_d   = word_buf_q;
        addr_d       = read_address;
        valid_d      = 1'b0;
        data_d       = serial_output_data;
        finished_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (run) begin
                    reverse_d = reverse;
                    if (word_count == CNT_W'(0)) begin
                        finished_d = 1'b1;
                    end else begin
                        addr_d       = start_address;
                        words_left_d = word_count;
                        state_d      = WAIT_MEM;
                    end
                end
            end
            WAIT_MEM: begin
                state_d = LATCH;
            end
            LATCH: begin
                word_buf_d = read_data;
                byte_idx_d = IDX_W'(0);
                addr_d     = reverse_q ? (read_address - ADDR_WIDTH'(1))
                                       : (read_address + ADDR_WIDTH'(1));
                state_d    = SEND;
            end
            SEND: begin
                if (!serial_output_active && !serial_output_valid) begin
                    valid_d = 1'b1;
                    data_d  = cur_byte_c;
                    if (last_byte_c) begin
                        words_left_d = words_left_q - CNT_W'(1);
                        if (words_left_q == CNT_W'(1)) begin
                            finished_d = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            state_d = WAIT_MEM;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d      = IDLE;
            words_left_d = words_left_q;
            byte_idx_d   = byte_idx_q;
            word_buf_d   = word_buf_q;
            addr_d       = read_address;
            valid_d      = 1'b0;
            data_d       = serial_output_data;
            finished_d   = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q             <= IDLE;
            reverse_q           <= 1'b0;
            words_left_q        <= '0;
            byte_idx_q          <= '0;
            word_buf_q          <= '0;
            read_address        <= '0;
            serial_output_valid <= 1'b0;
            serial_output_data  <= 8'd0;
            busy                <= 1'b0;
            finished            <= 1'b0;
        end else begin
            state_q             <= state_d;
            reverse_q           <= reverse_d;
            words_left_q        <= words_left_d;
            byte_idx_q          <= byte_idx_d;
            word_buf_q          <= word_buf_d;
            read_address        <= addr_d;
            serial_output_valid <= valid_d;
            serial_output_data  <= data_d;
            busy                <= busy_d;
            finished            <= finished_d;
        end
    end

endmodule

// File: tb/tb_capture_streamer.sv
// Bench for capture_streamer: three instances (1 byte/word, 4 bytes LSB first,
// 4 bytes MSB first) share a RAM image; a scoreboard queue holds expected bytes
// and a negedge monitor checks every strobe against it.
module tb_capture_streamer;

    localparam int AW = 13;
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [1:0] inst;
        logic [7:0] data;
        logic       fin;
    } exp_t;

    logic clock;
    logic reset_n;
    logic [2:0] run_v, abort_v, act_v, valid_v, busy_v, fin_v;
    logic reverse;
    logic [AW-1:0] start_address;
    logic [AW:0]   word_count;
    logic [2:0][AW-1:0] addr_v;
    logic [2:0][7:0]    data_v;
    logic [7:0]  rd0;
    logic [31:0] rd1, rd2;
    logic [31:0] mem [0:8191];
    logic [2:0][3:0] cnt;
    int hold;

    int tests = 0;
    int fails = 0;
    exp_t sb[$];
    int fin_lone [3];
    logic [2:0] prev_valid, prev_act;

    capture_streamer #(.ADDR_WIDTH(AW), .DATA_BYTES(1), .MSB_FIRST(1'b0)) dut0 (
        .clock(clock), .reset_n(reset_n), .run(run_v[0]), .abort(abort_v[0]),
        .reverse(reverse), .start_address(start_address), .word_count(word_count),
        .read_data(rd0), .read_address(addr_v[0]), .serial_output_active(act_v[0]),
        .serial_output_valid(valid_v[0]), .serial_output_data(data_v[0]),
        .busy(busy_v[0]), .finished(fin_v[0]));

    capture_streamer #(.ADDR_WIDTH(AW), .DATA_BYTES(4), .MSB_FIRST(1'b0)) dut1 (
        .clock(clock), .reset_n(reset_n), .run(run_v[1]), .abort(abort_v[1]),
        .reverse(reverse), .start_address(start_address), .word_count(word_count),
        .read_data(rd1), .read_address(addr_v[1]), .serial_output_active(act_v[1]),
        .serial_output_valid(valid_v[1]), .serial_output_data(data_v[1]),
        .busy(busy_v[1]), .finished(fin_v[1]));

    capture_streamer #(.ADDR_WIDTH(AW), .DATA_BYTES(4), .MSB_FIRST(1'b1)) dut2 (
        .clock(clock), .reset_n(reset_n), .run(run_v[2]), .abort(abort_v[2]),
        .reverse(reverse), .start_address(start_address), .word_count(word_count),
        .read_data(rd2), .read_address(addr_v[2]), .serial_output_active(act_v[2]),
        .serial_output_valid(valid_v[2]), .serial_output_data(data_v[2]),
        .busy(busy_v[2]), .finished(fin_v[2]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read RAM: data appears the cycle after the address.
    always @(posedge clock) begin
        rd0 <= mem[addr_v[0]][7:0];
        rd1 <= mem[addr_v[1]];
        rd2 <= mem[addr_v[2]];
    end

    // UART model: active high for 'hold' cycles starting the cycle after valid.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (valid_v[i]) cnt[i] <= 4'(hold);
                else if (cnt[i] != 4'd0) cnt[i] <= cnt[i] - 4'd1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) act_v[i] = (cnt[i] != 4'd0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pop and compare one expected entry per strobe, plus handshake rules.
    always @(negedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (valid_v[i]) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_strobe: inst %0d data %0h with nothing expected", i, data_v[i]);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("strobe_inst", 32'(i), 32'(e.inst));
                    check("strobe_data", 32'(data_v[i]), 32'(e.data));
                    check("strobe_finished", 32'(fin_v[i]), 32'(e.fin));
                end
                check("strobe_after_valid", 32'(prev_valid[i]), 32'd0);
                check("strobe_while_active", 32'(prev_act[i]), 32'd0);
            end else if (fin_v[i]) begin
                fin_lone[i]++;
            end
            prev_valid[i] = valid_v[i];
            prev_act[i]   = act_v[i];
        end
    end

    task automatic push(input int inst, input logic [7:0] d, input logic f);
        exp_t e;
        e.inst = 2'(inst);
        e.data = d;
        e.fin  = f;
        sb.push_back(e);
    endtask

    // Present run for one edge; returns #1 after the edge that sampled it.
    task automatic start(input int inst, input logic rev, input int sa, input int wc);
        reverse       = rev;
        start_address = AW'(sa);
        word_count    = CW'(wc);
        run_v[inst]   = 1'b1;
        @(posedge clock);
        #1;
        run_v = '0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clock);
            n++;
        end
        check(name, 32'(sb.size()), 32'd0);
        repeat (3) @(posedge clock);
        #1;
        check({name, "_idle"}, 32'(busy_v), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int seen;
        logic [31:0] w;

        for (int a = 0; a < 8192; a++) begin
            mem[a] = {8'hC3, 8'(a >> 5), 8'(a * 3), 8'(a) ^ 8'(a >> 8)};
        end
        mem[16'h10] = 32'h44332211;
        mem[16'h11] = 32'h88776655;

        reset_n = 1'b0;
        run_v = '0;
        abort_v = '0;
        reverse = 1'b0;
        start_address = '0;
        word_count = '0;
        hold = 0;
        prev_valid = '0;
        prev_act = '0;
        for (int i = 0; i < 3; i++) fin_lone[i] = 0;

        #12;
        check("rst_addr", 32'(addr_v[0]), 32'd0);
        check("rst_valid", 32'(valid_v), 32'd0);
        check("rst_data", 32'(data_v[0]), 32'd0);
        check("rst_busy", 32'(busy_v), 32'd0);
        check("rst_finished", 32'(fin_v), 32'd0);
        #10;
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Reverse single byte with exact latency.
        push(0, 8'h05, 1'b0);
        push(0, 8'h04, 1'b0);
        push(0, 8'h03, 1'b1);
        start(0, 1'b1, 5, 3);
        check("t1_busy_T1", 32'(busy_v[0]), 32'd1);
        check("t1_addr_T1", 32'(addr_v[0]), 32'd5);
        @(posedge clock); #1;
        check("t1_novalid_T1", 32'(valid_v[0]), 32'd0);
        @(posedge clock); #1;
        check("t1_novalid_T2", 32'(valid_v[0]), 32'd0);
        @(posedge clock); #1;
        check("t1_valid_T3", 32'(valid_v[0]), 32'd1);
        check("t1_data_T3", 32'(data_v[0]), 32'h05);
        drain("t1_drain", 100);

        // Reverse wrap through address 0.
        push(0, 8'h01, 1'b0);
        push(0, 8'h00, 1'b0);
        push(0, 8'hE0, 1'b1);
        start(0, 1'b1, 1, 3);
        check("t2_addr_start", 32'(addr_v[0]), 32'd1);
        drain("t2_drain", 100);
        check("t2_addr_end", 32'(addr_v[0]), 32'h1FFE);

        // Forward wrap through the top address.
        push(0, 8'hE1, 1'b0);
        push(0, 8'hE0, 1'b0);
        push(0, 8'h00, 1'b1);
        start(0, 1'b0, 'h1FFE, 3);
        drain("t2b_drain", 100);
        check("t2b_addr_end", 32'(addr_v[0]), 32'h0001);

        // Multi-byte, LSB first.
        push(1, 8'h11, 0); push(1, 8'h22, 0); push(1, 8'h33, 0); push(1, 8'h44, 0);
        push(1, 8'h55, 0); push(1, 8'h66, 0); push(1, 8'h77, 0); push(1, 8'h88, 1);
        start(1, 1'b0, 'h10, 2);
        drain("t3_drain", 200);
        check("t3_addr_end", 32'(addr_v[1]), 32'h12);

        // Multi-byte, MSB first.
        push(2, 8'h44, 0); push(2, 8'h33, 0); push(2, 8'h22, 0); push(2, 8'h11, 0);
        push(2, 8'h88, 0); push(2, 8'h77, 0); push(2, 8'h66, 0); push(2, 8'h55, 1);
        start(2, 1'b0, 'h10, 2);
        drain("t3m_drain", 200);

        // Zero count: lone finished pulse, never busy.
        base = fin_lone[0];
        start(0, 1'b0, 7, 0);
        check("t4_finished_T1", 32'(fin_v[0]), 32'd1);
        check("t4_busy_T1", 32'(busy_v[0]), 32'd0);
        seen = 0;
        repeat (5) begin
            @(posedge clock); #1;
            if (busy_v[0] || fin_v[0]) seen++;
        end
        check("t4_quiet_after", 32'(seen), 32'd0);
        check("t4_one_pulse", 32'(fin_lone[0] - base), 32'd1);

        // Slow UART over 8 words.
        hold = 10;
        for (int wd = 0; wd < 8; wd++) begin
            w = mem['h20 + wd];
            for (int k = 0; k < 4; k++) push(1, w[8*k +: 8], (wd == 7) && (k == 3));
        end
        start(1, 1'b0, 'h20, 8);
        drain("t5_drain", 2000);
        hold = 0;

        // Abort after second strobe, then restart.
        base = fin_lone[1];
        w = mem['h30];
        push(1, w[7:0], 0);
        push(1, w[15:8], 0);
        start(1, 1'b0, 'h30, 4);
        seen = 0;
        for (int n = 0; n < 50 && seen < 2; n++) begin
            @(posedge clock); #1;
            if (valid_v[1]) seen++;
        end
        check("t6_two_strobes", 32'(seen), 32'd2);
        @(posedge clock); #1;
        abort_v[1] = 1'b1;
        @(posedge clock); #1;
        abort_v[1] = 1'b0;
        check("t6_busy_after_abort", 32'(busy_v[1]), 32'd0);
        check("t6_valid_after_abort", 32'(valid_v[1]), 32'd0);
        repeat (10) @(posedge clock);
        #1;
        check("t6_no_more", 32'(sb.size()), 32'd0);
        check("t6_no_finished", 32'(fin_lone[1] - base), 32'd0);
        push(1, 8'h11, 0); push(1, 8'h22, 0); push(1, 8'h33, 0); push(1, 8'h44, 1);
        start(1, 1'b0, 'h10, 1);
        check("t6_restart_busy", 32'(busy_v[1]), 32'd1);
        drain("t6_restart_drain", 100);

        // Asynchronous reset mid-word.
        push(1, 8'h55, 0);
        start(1, 1'b0, 'h11, 2);
        seen = 0;
        for (int n = 0; n < 50 && seen == 0; n++) begin
            @(posedge clock); #1;
            if (valid_v[1]) seen++;
        end
        check("t7_first_strobe", 32'(seen), 32'd1);
        @(posedge clock); #1;
        #2;
        reset_n = 1'b0;
        #1;
        check("t7_rst_addr", 32'(addr_v[1]), 32'd0);
        check("t7_rst_valid", 32'(valid_v[1]), 32'd0);
        check("t7_rst_data", 32'(data_v[1]), 32'd0);
        check("t7_rst_busy", 32'(busy_v[1]), 32'd0);
        check("t7_rst_finished", 32'(fin_v[1]), 32'd0);
        check("t7_sb_empty", 32'(sb.size()), 32'd0);
        sb.delete();
        #20;
        reset_n = 1'b1;
        @(posedge clock); #1;
        push(0, 8'h09, 1'b1);
        start(0, 1'b0, 9, 1);
        drain("t7_recover_drain", 100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/capture_streamer.md
# capture_streamer

Parametrised successor to the single-byte capture readout. After a capture completes, it reads a configurable number of sample words from capture RAM, forwards or backwards, wrapping modulo RAM depth. It serialises each word into bytes for the UART transmitter using the existing valid/active byte handshake. It sits between the capture RAM read port and the serial output stage, and it is started and aborted by the command controller.

## Interface
- ADDR_WIDTH, 13, capture RAM address width; depth = 2^ADDR_WIDTH words
- DATA_BYTES, 1, bytes per RAM word (1..4); read_data width = 8*DATA_BYTES
- MSB_FIRST, 0, 0: byte 0 = read_data[7:0] sent first; 1: most significant byte first

- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  reset; one clock, reset is asynchronous and active-low
- run  in  1  start request; sampled only in IDLE
- abort  in  1  stop transfer; honoured in any non-IDLE state
- reverse  in  1  1: address decrements per word; 0: increments; latched at start
- start_address  in  ADDR_WIDTH  first word address; latched at start
- word_count  in  ADDR_WIDTH+1  words to send; latched at start
- read_data  in  8*DATA_BYTES  RAM read data, valid 1 cycle after read_address
- read_address  out  ADDR_WIDTH  RAM read address (registered)
- serial_output_active  in  1  UART busy; high from cycle after accepted valid until byte done
- serial_output_valid  out  1  one-cycle byte strobe
- serial_output_data  out  8  byte, held until next strobe
- busy  out  1  high in any non-IDLE state
- finished  out  1  one-cycle pulse on normal completion

## Operation
- States: IDLE, WAIT_MEM, LATCH, SEND.
- IDLE: on run, latch reverse/word_count. If word_count==0, pulse finished next cycle and stay IDLE. Otherwise read_address<=start_address, words_left<=word_count, go to WAIT_MEM.
- WAIT_MEM: one cycle of RAM latency, then go to LATCH.
- LATCH: word_buf<=read_data, byte_index<=0, read_address<=read_address±1 (mod 2^ADDR_WIDTH), go to SEND.
- SEND: issue a byte only when serial_output_active==0 and serial_output_valid==0. The strobe sets valid<=1 and data<=selected byte of word_buf.
  - If byte_index==DATA_BYTES-1, then words_left-=1. If words_left was 1, finished<=1 and go to IDLE. Otherwise go to WAIT_MEM.
  - Else byte_index+=1, stay in SEND.
- Byte selection: byte_index k → bits [8k+7:8k] (MSB_FIRST=0) or [8(DATA_BYTES-1-k)+7:…] (MSB_FIRST=1).
- Address wrap: reverse from 0 → 2^ADDR_WIDTH-1; forward from max → 0. A word_count above depth re-reads wrapped words; exactly word_count words are always sent.
- abort (non-IDLE) has priority over everything. Next state is IDLE, no strobe is issued that cycle, and finished does not pulse. A strobe already issued is not recalled.
- run while busy is ignored; start inputs may change freely while busy.

## Timing
- Reset values: read_address=0, serial_output_valid=0, serial_output_data=0, busy=0, finished=0, state IDLE. Asserting reset_n mid-transfer forces these immediately, without waiting for a clock edge.
- Cycle budget: run sampled at edge T. Then busy=1 and read_address=start at T+1, WAIT_MEM at T+1, LATCH at T+2, and the earliest first serial_output_valid at T+3.
- Consecutive strobes are separated by at least 2 cycles, because valid and then active block re-issue.
- Word boundary: at least 2 extra cycles (WAIT_MEM, LATCH) before the next word's first strobe.
- finished is high in the same cycle as the final valid strobe; busy is 0 from the next cycle.
- word_count==0: finished pulses at T+1, busy stays 0, no strobes.
- Abort at edge A: busy=0 from A+1.
- valid is never high for two consecutive cycles.

## Test plan
- Reverse, single byte. DATA_BYTES=1, mem[a]=a[7:0], reverse=1, start=5, count=3 → bytes 05,04,03; finished coincides with the 03 strobe; first strobe at T+3 with the UART idle.
- Reverse wrap. ADDR_WIDTH=13, reverse=1, start=1, count=3 → read_address sequence 1,0,0x1FFF; bytes mem[1],mem[0],mem[0x1FFF].
- Multi-byte forward. DATA_BYTES=4, mem[0x10]=0x44332211, mem[0x11]=0x88776655, start=0x10, count=2 → 11 22 33 44 55 66 77 88. With MSB_FIRST=1 → 44 33 22 11 88 77 66 55.
- Zero count. word_count=0 → finished pulse at T+1, no valid, busy never high.
- Handshake. Model holds active high for 10 cycles per byte → exactly one strobe per byte, no strobe while active or in the cycle after valid, and no bytes lost or duplicated over 8 words.
- Abort and reset. Abort after 2nd strobe of a 4-word run → no further strobes, no finished, busy=0 next cycle, and a new run is accepted. Separately, reset_n low mid-word → all outputs reach their reset values asynchronously.
